dbg_dump_unit: RTL and testbench

Synthesisable end-of-run state dump engine for the single-cycle MIPS core. It counts execution cycles and freezes the CPU at a programmed cycle limit or on a manual trigger. It then reads every register-file entry and a window of data-memory words through spare read ports and streams them out over a valid/ready interface. This replaces simulator-only register/memory printing and makes the same check usable on FPGA via a UART or logic-analyser sink.

---
 rtl/dbg_dump_unit.sv | 106 ++++++++++
 tb/tb_dbg_dump_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_dump_unit.sv
`timescale 1ns/1ps
// End-of-run dump engine: counts CPU cycles, halts on limit/trigger, streams regfile then data-memory words.
// Latency: halt on the trigger edge; first beat one cycle after entering REG; one beat per cycle thereafter.
// Backpressure: single output register; holds payload while dump_valid & !dump_ready, index advances only on a free slot.
module dbg_dump_unit #(
    parameter int CYCLE_LIMIT   = 45,
    parameter int NUM_REGS      = 32,
    parameter int MEM_BASE      = 0,
    parameter int NUM_MEM_WORDS = 9,
    parameter int MEM_AW        = 10,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              trig,
    output logic              cpu_halt,
    output logic [31:0]       cycle_cnt,
    output logic [4:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [MEM_AW-1:0] dm_raddr,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_is_mem,
    output logic [7:0]        dump_idx,
    output logic              done
);

    // S_DRAIN is the done-pending state: every beat is loaded, the last one awaits acceptance.
    typedef enum logic [2:0] {S_RUN, S_REG, S_MEM, S_DRAIN, S_DONE} state_t;

    localparam logic [15:0] REG_LAST = 16'(NUM_REGS - 1);
    localparam logic [15:0] MEM_LAST = 16'((NUM_MEM_WORDS > 0) ? NUM_MEM_WORDS - 1 : 0);
    localparam logic [32:0] LIMIT    = 33'(CYCLE_LIMIT);

    state_t      state, state_nxt;
    logic [15:0] idx;
    logic        slot_free;
    logic        limit_hit;
    logic        go;
    logic        idx_last;
    logic        load;

    assign slot_free = !dump_valid || dump_ready;
    // Widened compare so a saturated counter can never alias onto the limit.
    assign limit_hit = (CYCLE_LIMIT != 0) && en && (({1'b0, cycle_cnt} + 33'd1) == LIMIT);
    assign go        = trig || limit_hit;
    assign idx_last  = (state == S_REG) ? (idx == REG_LAST) : (idx == MEM_LAST);
    assign load      = slot_free && ((state == S_REG) || (state == S_MEM));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (go) state_nxt = S_REG;
            S_REG:   if (slot_free && idx_last) state_nxt = (NUM_MEM_WORDS != 0) ? S_MEM : S_DRAIN;
            S_MEM:   if (slot_free && idx_last) state_nxt = S_DRAIN;
            S_DRAIN: if (dump_ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    // Outputs decoded from state and the index counter; reads are combinational
    always_comb begin
        cpu_halt = (state != S_RUN);
        done     = (state == S_DONE);
        rf_raddr = idx[4:0];
        dm_raddr = MEM_AW'(MEM_BASE) + MEM_AW'(idx);
    end

    // Cycle counter, index counter and the output beat register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            idx         <= '0;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            dump_is_mem <= 1'b0;
            dump_idx    <= '0;
        end else begin
            if ((state == S_RUN) && en && (cycle_cnt != 32'hFFFF_FFFF))
                cycle_cnt <= cycle_cnt + 32'd1;
            if (load) begin
                dump_valid  <= 1'b1;
                // Register 0 is hardwired zero in MIPS, whatever the read port returns.
                if (state == S_REG) dump_data <= (idx == 16'd0) ? '0 : rf_rdata;
                else                dump_data <= dm_rdata;
                dump_is_mem <= (state == S_MEM);
                dump_idx    <= idx[7:0];
                idx         <= idx_last ? 16'd0 : idx + 16'd1;
            end else if (dump_valid && dump_ready) begin
                dump_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dbg_dump_unit.sv
`timescale 1ns/1ps
// Bench for dbg_dump_unit: four instances with different parameter sets, run one at a time.
// Stimulus pushes expected beats into a shared queue; a negedge monitor pops on every accepted beat.
// Stall monitor checks that a held beat keeps its payload and never drops without acceptance.
module tb_dbg_dump_unit;

    localparam int NI = 4;
    localparam int LIM [NI] = '{45, 0, 45, 45};
    localparam int NR  [NI] = '{32, 32, 8, 1};
    localparam int MB  [NI] = '{0, 0, 0, 1022};
    localparam int NM  [NI] = '{9, 9, 0, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        rst_v, en, trig, dump_ready, cpu_halt, dump_valid, dump_is_mem, done;
    logic [NI-1:0][31:0]  cycle_cnt, rf_rdata, dm_rdata, dump_data;
    logic [NI-1:0][4:0]   rf_raddr;
    logic [NI-1:0][9:0]   dm_raddr;
    logic [NI-1:0][7:0]   dump_idx;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            dbg_dump_unit #(
                .CYCLE_LIMIT(LIM[g]), .NUM_REGS(NR[g]), .MEM_BASE(MB[g]),
                .NUM_MEM_WORDS(NM[g]), .MEM_AW(10), .DATA_W(32)
            ) u_dut (
                .clk(clk), .rst(rst_v[g]), .en(en[g]), .trig(trig[g]),
                .cpu_halt(cpu_halt[g]), .cycle_cnt(cycle_cnt[g]),
                .rf_raddr(rf_raddr[g]), .rf_rdata(rf_rdata[g]),
                .dm_raddr(dm_raddr[g]), .dm_rdata(dm_rdata[g]),
                .dump_valid(dump_valid[g]), .dump_ready(dump_ready[g]),
                .dump_data(dump_data[g]), .dump_is_mem(dump_is_mem[g]),
                .dump_idx(dump_idx[g]), .done(done[g])
            );
            // Read ports return a tag plus the address so every beat identifies its source.
            assign rf_rdata[g] = 32'hA500_0000 | {27'd0, rf_raddr[g]};
            assign dm_rdata[g] = 32'hD000_0000 | {22'd0, dm_raddr[g]};
        end
    endgenerate

    int n_vec  = 0;
    int n_miss = 0;
    logic [40:0] exp_q[$];
    logic bp  = 1'b0;
    logic tog = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_beat(input logic m, input logic [7:0] i, input logic [31:0] d);
        exp_q.push_back({m, i, d});
    endtask

    task automatic push_regs(input int nr);
        for (int i = 0; i < nr; i++)
            push_beat(1'b0, 8'(i), (i == 0) ? 32'd0 : (32'hA500_0000 | 32'(i)));
    endtask

    task automatic push_mem(input int base, input int nm);
        for (int j = 0; j < nm; j++)
            push_beat(1'b1, 8'(j), 32'hD000_0000 | 32'((base + j) & 1023));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int k, input int budget);
        int n;
        n = 0;
        while (!done[k] && n < budget) begin
            tick(1);
            n++;
        end
        chk($sformatf("done_reached_%0d", k), 64'(done[k]), 64'd1);
    endtask

    // Sink ready: constant 1, or alternating 1010... when bp is set
    initial begin
        dump_ready = '1;
        forever begin
            @(posedge clk);
            #1;
            tog = ~tog;
            dump_ready = bp ? {NI{tog}} : {NI{1'b1}};
        end
    end

    // Monitor: pop and compare each accepted beat, and check stalled beats stay put
    initial begin
        logic [NI-1:0]       stalled;
        logic [NI-1:0][41:0] held;
        logic [41:0]         cur;
        stalled = '0;
        held    = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                cur = {dump_valid[k], dump_is_mem[k], dump_idx[k], dump_data[k]};
                if (rst_v[k]) begin
                    stalled[k] = 1'b0;
                end else begin
                    if (stalled[k])
                        chk($sformatf("stall_hold_%0d", k), 64'(cur), 64'(held[k]));
                    if (dump_valid[k] && dump_ready[k]) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_miss++;
                            $display("FAIL extra_beat_%0d: got %0h expected no beat", k, cur[40:0]);
                        end else begin
                            chk($sformatf("beat_%0d", k), 64'(cur[40:0]), 64'(exp_q.pop_front()));
                        end
                    end
                    stalled[k] = dump_valid[k] && !dump_ready[k];
                    held[k]    = cur;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v = '1;
        en    = '0;
        trig  = '0;
        tick(2);

        // Reset values
        chk("rst_halt",   64'(cpu_halt[0]),    64'd0);
        chk("rst_cnt",    64'(cycle_cnt[0]),   64'd0);
        chk("rst_valid",  64'(dump_valid[0]),  64'd0);
        chk("rst_done",   64'(done[0]),        64'd0);
        chk("rst_rfaddr", 64'(rf_raddr[0]),    64'd0);
        chk("rst_dmaddr", 64'(dm_raddr[0]),    64'd0);
        chk("rst_data",   64'(dump_data[0]),   64'd0);
        chk("rst_idx",    64'(dump_idx[0]),    64'd0);
        chk("rst_ismem",  64'(dump_is_mem[0]), 64'd0);
        chk("rst_dmaddr_base", 64'(dm_raddr[3]), 64'h3FE);

        // Auto-trigger at 45 with defaults, sink always ready
        push_regs(32);
        push_mem(0, 9);
        en[0] = 1'b1;
        rst_v[0] = 1'b0;
        tick(44);
        chk("t1_halt_pre", 64'(cpu_halt[0]),  64'd0);
        chk("t1_cnt_pre",  64'(cycle_cnt[0]), 64'd44);
        tick(1);
        chk("t1_halt",     64'(cpu_halt[0]),  64'd1);
        chk("t1_cnt",      64'(cycle_cnt[0]), 64'd45);
        chk("t1_valid_lat", 64'(dump_valid[0]), 64'd0);
        tick(1);
        chk("t1_first_valid", 64'(dump_valid[0]), 64'd1);
        chk("t1_first_data",  64'(dump_data[0]),  64'd0);
        tick(40);
        chk("t1_last_valid", 64'(dump_valid[0]),  64'd1);
        chk("t1_last_idx",   64'(dump_idx[0]),    64'd8);
        chk("t1_last_ismem", 64'(dump_is_mem[0]), 64'd1);
        chk("t1_done_early", 64'(done[0]),        64'd0);
        tick(1);
        chk("t1_done",       64'(done[0]),        64'd1);
        chk("t1_valid_done", 64'(dump_valid[0]),  64'd0);
        chk("t1_cnt_frozen", 64'(cycle_cnt[0]),   64'd45);
        chk("t1_q_empty",    64'(exp_q.size()),   64'd0);

        // Trig coincident with the limit hit, sink toggling 1010...
        rst_v[0] = 1'b1;
        tick(1);
        push_regs(32);
        push_mem(0, 9);
        bp = 1'b1;
        rst_v[0] = 1'b0;
        tick(44);
        trig[0] = 1'b1;
        tick(1);
        trig[0] = 1'b0;
        chk("t2_halt", 64'(cpu_halt[0]),  64'd1);
        chk("t2_cnt",  64'(cycle_cnt[0]), 64'd45);
        wait_done(0, 300);
        tick(10);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset asserted after beat 5 has been accepted
        bp = 1'b0;
        rst_v[0] = 1'b1;
        tick(2);
        push_regs(6);
        rst_v[0] = 1'b0;
        tick(52);
        rst_v[0] = 1'b1;
        #1;
        chk("t3_halt",  64'(cpu_halt[0]),   64'd0);
        chk("t3_valid", 64'(dump_valid[0]), 64'd0);
        chk("t3_cnt",   64'(cycle_cnt[0]),  64'd0);
        chk("t3_done",  64'(done[0]),       64'd0);
        chk("t3_data",  64'(dump_data[0]),  64'd0);
        chk("t3_idx",   64'(dump_idx[0]),   64'd0);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
        tick(1);
        rst_v[0] = 1'b0;
        tick(3);
        chk("t3_restart_cnt",  64'(cycle_cnt[0]), 64'd3);
        chk("t3_restart_halt", 64'(cpu_halt[0]),  64'd0);
        rst_v[0] = 1'b1;
        en[0] = 1'b0;

        // Manual trig, auto-trigger disabled; later trigs are ignored
        push_regs(32);
        push_mem(0, 9);
        en[1] = 1'b1;
        rst_v[1] = 1'b0;
        tick(9);
        chk("t4_cnt_pre", 64'(cycle_cnt[1]), 64'd9);
        trig[1] = 1'b1;
        tick(1);
        trig[1] = 1'b0;
        chk("t4_cnt",  64'(cycle_cnt[1]), 64'd10);
        chk("t4_halt", 64'(cpu_halt[1]),  64'd1);
        tick(10);
        trig[1] = 1'b1;
        tick(1);
        trig[1] = 1'b0;
        wait_done(1, 200);
        tick(3);
        trig[1] = 1'b1;
        tick(1);
        trig[1] = 1'b0;
        tick(10);
        chk("t4_cnt_frozen", 64'(cycle_cnt[1]), 64'd10);
        chk("t4_done_held",  64'(done[1]),      64'd1);
        chk("t4_q_empty",    64'(exp_q.size()), 64'd0);
        rst_v[1] = 1'b1;

        // Eight registers, no memory phase
        push_regs(8);
        en[2] = 1'b1;
        rst_v[2] = 1'b0;
        trig[2] = 1'b1;
        tick(1);
        trig[2] = 1'b0;
        chk("t5_cnt", 64'(cycle_cnt[2]), 64'd1);
        wait_done(2, 100);
        tick(5);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);
        rst_v[2] = 1'b1;

        // Memory window wrapping past the top of a 10-bit address space
        bp = 1'b1;
        push_beat(1'b0, 8'd0, 32'h0000_0000);
        push_beat(1'b1, 8'd0, 32'hD000_03FE);
        push_beat(1'b1, 8'd1, 32'hD000_03FF);
        push_beat(1'b1, 8'd2, 32'hD000_0000);
        push_beat(1'b1, 8'd3, 32'hD000_0001);
        en[3] = 1'b1;
        rst_v[3] = 1'b0;
        trig[3] = 1'b1;
        tick(1);
        trig[3] = 1'b0;
        wait_done(3, 100);
        tick(5);
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
